// File: rtl/nonce_batch_scheduler_if.sv
// Engine-side link of the nonce batch scheduler: one-cycle launch plus a per-lane result stream.
interface nonce_batch_scheduler_if #(
  parameter int IDXW = 4
);
  // Handshake: eng_start is a one-cycle launch; eng_nonce_base holds from launch until eng_done.
  // Results are valid-only (no ready): every cycle with eng_res_valid high carries one lane result that
  // the scheduler must take; eng_done ends the batch and may coincide with the last result.
  logic            eng_start;
  logic [31:0]     eng_nonce_base;
  logic            eng_res_valid;
  logic [IDXW-1:0] eng_res_idx;
  logic [31:0]     eng_res_h0;
  logic            eng_done;

  modport master (
    output eng_start, eng_nonce_base,
    input  eng_res_valid, eng_res_idx, eng_res_h0, eng_done
  );

  modport slave (
    input  eng_start, eng_nonce_base,
    output eng_res_valid, eng_res_idx, eng_res_h0, eng_done
  );
endinterface

// File: rtl/nonce_batch_scheduler.sv
// Drives the parallel SHA-256 nonce engine batch after batch, keeping the lowest h0 at or under target.
module nonce_batch_scheduler #(
  parameter int NONCES = 16,
  parameter int IDXW   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] cfg_nonce_start,
  input  logic [31:0] cfg_target,
  input  logic [15:0] cfg_max_batches,
  input  logic        cfg_stop_on_find,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] best_nonce,
  output logic [31:0] best_h0,
  output logic [15:0] batches_run,
  output logic [2:0]  dbg_state,
  nonce_batch_scheduler_if.master eng
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]  state;
  logic [31:0] target_q;
  logic [15:0] max_q;
  logic        stop_q;
  logic        abort_q;
  logic        lane_ok;
  logic        hit;
  logic        last_batch;
  logic [31:0] cand;
  logic [16:0] batches_inc;

  generate
    if (NONCES >= (1 << IDXW)) begin : g_full_idx
      assign lane_ok = 1'b1;
    end else begin : g_part_idx
      assign lane_ok = ({1'b0, eng.eng_res_idx} < (IDXW+1)'(NONCES));
    end
  endgenerate

  assign cand        = eng.eng_nonce_base + 32'(eng.eng_res_idx);
  // Strict less-than against the current best keeps the earlier result on ties.
  assign hit         = (state == S_WAIT) && eng.eng_res_valid && lane_ok &&
                       (eng.eng_res_h0 <= target_q) && (!found || (eng.eng_res_h0 < best_h0));
  assign batches_inc = {1'b0, batches_run} + 17'd1;
  assign last_batch  = abort_q || abort || (stop_q && found) ||
                       ((max_q != 16'd0) && (batches_inc == {1'b0, max_q}));
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      busy               <= 1'b0;
      done               <= 1'b0;
      found              <= 1'b0;
      best_nonce         <= 32'd0;
      best_h0            <= 32'hFFFF_FFFF;
      batches_run        <= 16'd0;
      eng.eng_start      <= 1'b0;
      eng.eng_nonce_base <= 32'd0;
      target_q           <= 32'd0;
      max_q              <= 16'd0;
      stop_q             <= 1'b0;
      abort_q            <= 1'b0;
    end else begin
      done          <= 1'b0;
      eng.eng_start <= 1'b0;
      if ((state != S_IDLE) && abort) abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            target_q           <= cfg_target;
            max_q              <= cfg_max_batches;
            stop_q             <= cfg_stop_on_find;
            abort_q            <= 1'b0;
            eng.eng_nonce_base <= cfg_nonce_start;
            found              <= 1'b0;
            batches_run        <= 16'd0;
            best_h0            <= 32'hFFFF_FFFF;
            busy               <= 1'b1;
            state              <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          eng.eng_start <= 1'b1;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (hit) begin
            best_h0    <= eng.eng_res_h0;
            best_nonce <= cand;
            found      <= 1'b1;
          end
          if (eng.eng_done) state <= S_NEXT;
        end
        S_NEXT: begin
          if (batches_run != 16'hFFFF) batches_run <= batches_run + 16'd1;
          // Relaunch straight from here so the engine sees its next start two cycles after done.
          if (last_batch) begin
            done  <= 1'b1;
            state <= S_REPORT;
          end else begin
            eng.eng_nonce_base <= eng.eng_nonce_base + 32'(NONCES);
            eng.eng_start      <= 1'b1;
            state              <= S_WAIT;
          end
        end
        S_REPORT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nonce_batch_scheduler.sv
// Directed bench for nonce_batch_scheduler: engine driver, timing/result scoreboard and literal checks.
module tb_nonce_batch_scheduler;
  localparam int NONCES = 16;
  localparam int IDXW   = 4;
  localparam int NEVER  = 1 << 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_nonce_start = 32'd0;
  logic [31:0] cfg_target = 32'd0;
  logic [15:0] cfg_max_batches = 16'd0;
  logic        cfg_stop_on_find = 1'b0;
  logic        busy, done, found;
  logic [31:0] best_nonce, best_h0;
  logic [15:0] batches_run;
  logic [2:0]  dbg_state;

  nonce_batch_scheduler_if #(.IDXW(IDXW)) eng ();

  nonce_batch_scheduler #(.NONCES(NONCES), .IDXW(IDXW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .cfg_nonce_start(cfg_nonce_start), .cfg_target(cfg_target),
    .cfg_max_batches(cfg_max_batches), .cfg_stop_on_find(cfg_stop_on_find),
    .busy(busy), .done(done), .found(found), .best_nonce(best_nonce), .best_h0(best_h0),
    .batches_run(batches_run), .dbg_state(dbg_state), .eng(eng)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- model state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] mdl_nonce[$];
  logic [31:0] mdl_h0[$];
  logic [31:0] mdl_tgt = 32'd0;
  int          mdl_batches = 0;
  int          start_due = -1;
  int          done_due = -1;
  int          busy_from = NEVER;
  int          busy_until = 0;

  logic [31:0] res_h0[NONCES];
  bit          res_en[NONCES];

  function automatic void fill(logic [31:0] off);
    for (int i = 0; i < NONCES; i++) begin
      res_en[i] = 1'b1;
      res_h0[i] = off + 32'(i);
    end
  endfunction

  function automatic void note_done(bit last);
    int trig;
    trig = cyc + 1;
    mdl_batches++;
    if (last) begin
      done_due   = trig + 2;
      busy_until = trig + 2;
    end else begin
      start_due = trig + 2;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_search(input logic [31:0] base, input logic [31:0] tgt,
                              input logic [15:0] mx, input bit stop);
    @(negedge clk);
    cfg_nonce_start  = base;
    cfg_target       = tgt;
    cfg_max_batches  = mx;
    cfg_stop_on_find = stop;
    start            = 1'b1;
    mdl_nonce.delete();
    mdl_h0.delete();
    mdl_tgt     = tgt;
    mdl_batches = 0;
    start_due   = cyc + 3;
    busy_from   = cyc + 2;
    busy_until  = NEVER;
    done_due    = -1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_batch(input logic [31:0] base, input bit last, input bit dwl,
                           input bit abort_mid, input bit poke);
    bit got;
    int last_lane;
    exp_q.push_back(base);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = eng.eng_start;
    end
    chk("launch_seen", 32'(got), 32'd1);
    if (!got) return;
    last_lane = -1;
    for (int i = 0; i < NONCES; i++) if (res_en[i]) last_lane = i;
    for (int i = 0; i < NONCES; i++) begin
      if (res_en[i]) begin
        eng.eng_res_valid = 1'b1;
        eng.eng_res_idx   = IDXW'(i);
        eng.eng_res_h0    = res_h0[i];
        abort = abort_mid && (i == 5);
        start = poke && (i == 3);
        mdl_nonce.push_back(base + 32'(i));
        mdl_h0.push_back(res_h0[i]);
        if (dwl && (i == last_lane)) begin
          eng.eng_done = 1'b1;
          note_done(last);
        end
        @(negedge clk);
      end
    end
    eng.eng_res_valid = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    if (!dwl) begin
      eng.eng_done = 1'b1;
      note_done(last);
      @(negedge clk);
    end
    eng.eng_done = 1'b0;
  endtask

  // ---------------- scoreboard: every cycle out of reset ----------------
  initial begin : cmp_proc
    int lab;
    logic [31:0] hits[$];
    logic [31:0] mn[$];
    int ix[$];
    logic [31:0] eb;
    forever begin
      @(posedge clk);
      #2;
      if (reset_n) begin
        lab = cyc + 1;
        chk("eng_start", 32'(eng.eng_start), 32'(lab == start_due));
        chk("busy", 32'(busy), 32'((lab >= busy_from) && (lab <= busy_until)));
        chk("done", 32'(done), 32'(lab == done_due));
        if (eng.eng_start && exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          chk("eng_nonce_base", eng.eng_nonce_base, eb);
        end
        if (lab == done_due) begin
          hits = mdl_h0.find with (item <= mdl_tgt);
          chk("batches_run", 32'(batches_run), 32'(mdl_batches));
          chk("found", 32'(found), 32'(hits.size() > 0));
          if (hits.size() == 0) begin
            chk("best_h0", best_h0, 32'hFFFF_FFFF);
          end else begin
            mn = hits.min();
            ix = mdl_h0.find_first_index with (item == mn[0]);
            chk("best_h0", best_h0, mn[0]);
            chk("best_nonce", best_nonce, mdl_nonce[ix[0]]);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    bit got;
    eng.eng_res_valid = 1'b0;
    eng.eng_res_idx   = '0;
    eng.eng_res_h0    = 32'd0;
    eng.eng_done      = 1'b0;
    for (int i = 0; i < NONCES; i++) begin
      res_en[i] = 1'b0;
      res_h0[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_best_nonce", best_nonce, 32'd0);
    chk("rst_best_h0", best_h0, 32'hFFFF_FFFF);
    chk("rst_batches", 32'(batches_run), 32'd0);
    chk("rst_eng_start", 32'(eng.eng_start), 32'd0);
    chk("rst_eng_base", eng.eng_nonce_base, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // single batch, nothing under target 0
    start_search(32'd0, 32'd0, 16'd1, 1'b0);
    fill(32'd1);
    run_batch(32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t1_found", 32'(found), 32'd0);
    chk("t1_batches", 32'(batches_run), 32'd1);
    chk("t1_best_h0", best_h0, 32'hFFFF_FFFF);

    // stop on find in batch 3; a start during busy with new cfg must be ignored
    start_search(32'd100, 32'd10, 16'd0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      fill(32'd1000);
      if (b == 2) res_h0[7] = 32'd5;
      if (b == 1) begin
        cfg_nonce_start = 32'hDEAD_0000;
        cfg_target      = 32'hFFFF_FFFF;
      end
      run_batch(32'd100 + 32'(16 * b), b == 2, 1'b0, 1'b0, b == 1);
    end
    repeat (4) @(negedge clk);
    chk("t2_found", 32'(found), 32'd1);
    chk("t2_best_nonce", best_nonce, 32'd139);
    chk("t2_best_h0", best_h0, 32'd5);
    chk("t2_batches", 32'(batches_run), 32'd3);

    // best of many with a tie in the second batch
    start_search(32'd200, 32'hFFFF_FFFF, 16'd2, 1'b0);
    fill(32'd1000);
    res_h0[2] = 32'd50;
    run_batch(32'd200, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(32'd1000);
    res_h0[9]  = 32'd20;
    res_h0[10] = 32'd20;
    run_batch(32'd216, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t3_best_nonce", best_nonce, 32'd225);
    chk("t3_best_h0", best_h0, 32'd20);
    chk("t3_batches", 32'(batches_run), 32'd2);

    // nonce base wraps through zero
    start_search(32'hFFFF_FFF8, 32'h100, 16'd2, 1'b0);
    fill(32'd1000);
    res_h0[9] = 32'd3;
    run_batch(32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(32'd1000);
    run_batch(32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t4_best_nonce", best_nonce, 32'h0000_0001);
    chk("t4_best_h0", best_h0, 32'd3);
    chk("t4_base", eng.eng_nonce_base, 32'h0000_0008);

    // abort pulse mid batch 1 of an unlimited run; batch 1 still evaluated
    start_search(32'h5000, 32'd0, 16'd0, 1'b0);
    fill(32'd1);
    run_batch(32'h5000, 1'b0, 1'b0, 1'b0, 1'b0);
    fill(32'd1);
    res_h0[4] = 32'd0;
    run_batch(32'h5010, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("t5_found", 32'(found), 32'd1);
    chk("t5_best_nonce", best_nonce, 32'h5014);
    chk("t5_best_h0", best_h0, 32'd0);
    chk("t5_batches", 32'(batches_run), 32'd2);

    // results and eng_done in IDLE are ignored; lane 15 arriving with eng_done is counted
    @(negedge clk);
    eng.eng_res_valid = 1'b1;
    eng.eng_res_idx   = IDXW'(3);
    eng.eng_res_h0    = 32'd0;
    eng.eng_done      = 1'b1;
    @(negedge clk);
    eng.eng_res_valid = 1'b0;
    eng.eng_done      = 1'b0;
    start_search(32'h1000, 32'd100, 16'd1, 1'b0);
    for (int i = 0; i < NONCES; i++) res_en[i] = 1'b0;
    res_en[15] = 1'b1;
    res_h0[15] = 32'd7;
    run_batch(32'h1000, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("t6_found", 32'(found), 32'd1);
    chk("t6_best_nonce", best_nonce, 32'h100F);
    chk("t6_best_h0", best_h0, 32'd7);

    // reset in WAIT returns everything to reset values
    start_search(32'h2000, 32'hFFFF_FFFF, 16'd0, 1'b0);
    exp_q.push_back(32'h2000);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = eng.eng_start;
    end
    chk("t7_launch_seen", 32'(got), 32'd1);
    for (int i = 0; i < 2; i++) begin
      eng.eng_res_valid = 1'b1;
      eng.eng_res_idx   = IDXW'(i);
      eng.eng_res_h0    = 32'(i + 1);
      @(negedge clk);
    end
    eng.eng_res_valid = 1'b0;
    reset_n = 1'b0;
    exp_q.delete();
    start_due = -1;
    done_due  = -1;
    busy_from = NEVER;
    #1;
    chk("t7_busy", 32'(busy), 32'd0);
    chk("t7_found", 32'(found), 32'd0);
    chk("t7_best_nonce", best_nonce, 32'd0);
    chk("t7_best_h0", best_h0, 32'hFFFF_FFFF);
    chk("t7_batches", 32'(batches_run), 32'd0);
    chk("t7_eng_start", 32'(eng.eng_start), 32'd0);
    chk("t7_eng_base", eng.eng_nonce_base, 32'd0);
    chk("t7_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t7_idle_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
